// File: rtl/sd_framer_pkg.sv
// Shared definitions for the sd_framer block.
//
// Contents:
//   state_e      - framer state encoding (s_idle = 1'b0, s_xfer = 1'b1)
//   s_idle_enc   - raw encoding of s_idle
//   s_xfer_enc   - raw encoding of s_xfer
//   len_is_last  - helper: true when a remaining-word count marks the final word
package sd_framer_pkg;

  localparam logic s_idle_enc = 1'b0;
  localparam logic s_xfer_enc = 1'b1;

  typedef enum logic {
    s_idle = s_idle_enc,
    s_xfer = s_xfer_enc
  } state_e;

  // The remaining count holds "words left minus one", so zero marks the final word.
  function automatic logic len_is_last(input logic [31:0] remaining);
    return (remaining == 32'd0);
  endfunction

endpackage

// File: rtl/sd_framer.sv
// Frame sequencer: accepts a frame-length command, then marks the first and last words of
// the frame as they pass from an external upstream data path to the downstream consumer.
// Back-to-back commands are loaded on the last beat, so consecutive frames have no bubble.
//
// Ports:
//   clk          - clock, all state updates on the rising edge
//   reset        - asynchronous active-low reset
//   ic_srdy      - frame command valid
//   ic_len       - frame length in words minus one
//   nic_drdy     - command accepted (combinational)
//   c_srdy       - upstream word valid
//   nc_drdy      - upstream word accepted (combinational)
//   np_srdy      - downstream word valid (combinational)
//   p_drdy       - downstream ready
//   np_fr_start  - current downstream word is the first of its frame
//   np_fr_end    - current downstream word is the last of its frame
//   frame_cnt    - count of completed frames, wraps silently
//   active       - high while a frame is in progress
module sd_framer
  import sd_framer_pkg::*;
#(
  parameter int unsigned len_sz = 8,
  parameter int unsigned cnt_sz = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_srdy,
  input  logic [len_sz-1:0] ic_len,
  output logic              nic_drdy,
  input  logic              c_srdy,
  output logic              nc_drdy,
  output logic              np_srdy,
  input  logic              p_drdy,
  output logic              np_fr_start,
  output logic              np_fr_end,
  output logic [cnt_sz-1:0] frame_cnt,
  output logic              active
);

  state_e              state_q;
  logic [len_sz-1:0]   remaining_q;
  logic                first_q;
  logic [cnt_sz-1:0]   frame_cnt_q;

  logic                in_xfer;
  logic                on_last;
  logic                beat;
  logic                last_beat;

  assign in_xfer   = (state_q == s_xfer);
  assign on_last   = len_is_last(32'(remaining_q));
  assign beat      = in_xfer & c_srdy & p_drdy;
  assign last_beat = beat & on_last;

  // Handshake outputs are combinational so a new command can be taken on the last beat.
  always_comb begin
    nic_drdy = 1'b0;
    nc_drdy  = 1'b0;
    np_srdy  = 1'b0;
    case (state_q)
      s_idle: begin
        nic_drdy = 1'b1;
      end
      s_xfer: begin
        np_srdy  = c_srdy;
        nc_drdy  = p_drdy;
        nic_drdy = last_beat;
      end
      default: begin
        nic_drdy = 1'b0;
      end
    endcase
  end

  assign np_fr_start = np_srdy & first_q;
  assign np_fr_end   = np_srdy & on_last;
  assign frame_cnt   = frame_cnt_q;
  assign active      = in_xfer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= s_idle;
      remaining_q <= '0;
      first_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      case (state_q)
        s_idle: begin
          if (ic_srdy) begin
            remaining_q <= ic_len;
            first_q     <= 1'b1;
            state_q     <= s_xfer;
          end
        end
        s_xfer: begin
          if (beat) begin
            if (on_last) begin
              frame_cnt_q <= frame_cnt_q + cnt_sz'(1);
              if (ic_srdy) begin
                // Zero-bubble chaining: next frame starts on the following cycle.
                remaining_q <= ic_len;
                first_q     <= 1'b1;
              end else begin
                first_q <= 1'b0;
                state_q <= s_idle;
              end
            end else begin
              remaining_q <= remaining_q - len_sz'(1);
              first_q     <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= s_idle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_framer.sv
// Bench for sd_framer: a directed vector table, hand-written stall and reset sequences, and
// randomized traffic checked against a word-counting frame model.
module tb_sd_framer;

  localparam int LenSz = 8;
  localparam int CntSz = 2;

  logic             clk;
  logic             reset;
  logic             ic_srdy;
  logic [LenSz-1:0] ic_len;
  logic             nic_drdy;
  logic             c_srdy;
  logic             nc_drdy;
  logic             np_srdy;
  logic             p_drdy;
  logic             np_fr_start;
  logic             np_fr_end;
  logic [CntSz-1:0] frame_cnt;
  logic             active;

  sd_framer #(
    .len_sz(LenSz),
    .cnt_sz(CntSz)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ic_srdy    (ic_srdy),
    .ic_len     (ic_len),
    .nic_drdy   (nic_drdy),
    .c_srdy     (c_srdy),
    .nc_drdy    (nc_drdy),
    .np_srdy    (np_srdy),
    .p_drdy     (p_drdy),
    .np_fr_start(np_fr_start),
    .np_fr_end  (np_fr_end),
    .frame_cnt  (frame_cnt),
    .active     (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Frame model: words still to send in the current frame (0 = no frame), words already sent.
  int m_left = 0;
  int m_done = 0;
  int m_cnt  = 0;

  typedef struct {
    logic       ic;
    logic [7:0] len;
    logic       c;
    logic       p;
    logic       nic;
    logic       nc;
    logic       np;
    logic       st;
    logic       en;
    int         cnt;
    logic       act;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(logic ic, logic [7:0] len, logic c, logic p, logic nic,
                              logic nc, logic np, logic st, logic en, int cnt, logic act);
    vec_t v;
    v.ic = ic; v.len = len; v.c = c; v.p = p;
    v.nic = nic; v.nc = nc; v.np = np; v.st = st; v.en = en; v.cnt = cnt; v.act = act;
    return v;
  endfunction

  task automatic check_outs(input string name, input logic e_nic, input logic e_nc,
                            input logic e_np, input logic e_st, input logic e_en,
                            input int e_cnt, input logic e_act);
    logic [CntSz-1:0] ec;
    ec = e_cnt[CntSz-1:0];
    n_tests++;
    if ({nic_drdy, nc_drdy, np_srdy, np_fr_start, np_fr_end, active} !==
        {e_nic, e_nc, e_np, e_st, e_en, e_act} || frame_cnt !== ec) begin
      n_fail++;
      $display("FAIL %s: got nic=%b nc=%b np=%b st=%b en=%b cnt=%0d act=%b, want nic=%b nc=%b np=%b st=%b en=%b cnt=%0d act=%b",
               name, nic_drdy, nc_drdy, np_srdy, np_fr_start, np_fr_end, frame_cnt, active,
               e_nic, e_nc, e_np, e_st, e_en, ec, e_act);
    end
  endtask

  task automatic model_check(input string name);
    logic busy;
    logic e_np;
    busy = (m_left > 0);
    e_np = busy & c_srdy;
    if (!busy) check_outs(name, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, m_cnt, 1'b0);
    else check_outs(name, c_srdy & p_drdy & (m_left == 1), p_drdy, e_np, e_np & (m_done == 0),
                    e_np & (m_left == 1), m_cnt, 1'b1);
  endtask

  task automatic model_update();
    if (m_left == 0) begin
      if (ic_srdy) begin
        m_left = int'(ic_len) + 1;
        m_done = 0;
      end
    end else if (c_srdy && p_drdy) begin
      m_left--;
      m_done++;
      if (m_left == 0) begin
        m_cnt = (m_cnt + 1) % (1 << CntSz);
        if (ic_srdy) begin
          m_left = int'(ic_len) + 1;
          m_done = 0;
        end
      end
    end
  endtask

  // One clock cycle under the model; reports whether a frame-end beat occurred.
  task automatic step(input logic ic, input logic [LenSz-1:0] len, input logic c, input logic p,
                      input string name, output logic beat_seen, output logic end_seen);
    @(negedge clk);
    ic_srdy = ic; ic_len = len; c_srdy = c; p_drdy = p;
    #1;
    beat_seen = np_srdy & p_drdy;
    end_seen  = np_fr_end & p_drdy;
    model_check(name);
    @(posedge clk);
    model_update();
  endtask

  task automatic do_reset(input string name);
    @(negedge clk);
    reset = 1'b0;
    ic_srdy = 1'b0; c_srdy = 1'b1; p_drdy = 1'b1; ic_len = '0;
    #1;
    m_left = 0; m_done = 0; m_cnt = 0;
    check_outs(name, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic b, e;
    int beats, end_beat;
    reset = 1'b0; ic_srdy = 1'b0; ic_len = '0; c_srdy = 1'b0; p_drdy = 1'b0;

    // ic len c p | nic nc np st en cnt act
    vecs[0]  = mk(1, 8'd3, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 8'd0, 1, 1, 0, 1, 1, 1, 0, 0, 1);
    vecs[2]  = mk(0, 8'd0, 1, 1, 0, 1, 1, 0, 0, 0, 1);
    vecs[3]  = mk(0, 8'd0, 1, 1, 0, 1, 1, 0, 0, 0, 1);
    vecs[4]  = mk(0, 8'd0, 1, 1, 1, 1, 1, 0, 1, 0, 1);
    vecs[5]  = mk(1, 8'd0, 1, 1, 1, 0, 0, 0, 0, 1, 0);
    vecs[6]  = mk(0, 8'd0, 1, 1, 1, 1, 1, 1, 1, 1, 1);
    vecs[7]  = mk(1, 8'd1, 1, 1, 1, 0, 0, 0, 0, 2, 0);
    vecs[8]  = mk(0, 8'd0, 1, 1, 0, 1, 1, 1, 0, 2, 1);
    vecs[9]  = mk(1, 8'd2, 1, 1, 1, 1, 1, 0, 1, 2, 1);
    vecs[10] = mk(0, 8'd0, 1, 1, 0, 1, 1, 1, 0, 3, 1);
    vecs[11] = mk(0, 8'd0, 1, 1, 0, 1, 1, 0, 0, 3, 1);
    vecs[12] = mk(0, 8'd0, 1, 1, 1, 1, 1, 0, 1, 3, 1);
    vecs[13] = mk(1, 8'd0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    vecs[14] = mk(0, 8'd0, 1, 1, 1, 1, 1, 1, 1, 0, 1);
    vecs[15] = mk(0, 8'd0, 1, 1, 1, 0, 0, 0, 0, 1, 0);

    do_reset("reset_initial");

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      ic_srdy = vecs[i].ic; ic_len = vecs[i].len; c_srdy = vecs[i].c; p_drdy = vecs[i].p;
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i].nic, vecs[i].nc, vecs[i].np, vecs[i].st,
                 vecs[i].en, vecs[i].cnt, vecs[i].act);
    end

    // Stall mid-frame: 5-word frame, downstream not ready for 3 cycles after beat 2.
    do_reset("reset_stall");
    step(1, 8'd4, 1, 1, "stall_cmd", b, e);
    beats = 0; end_beat = 0;
    for (int i = 0; i < 2; i++) begin
      step(0, 8'd0, 1, 1, "stall_pre", b, e);
      if (b) beats++;
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 8'd0, 1, 0, "stall_hold", b, e);
      if (b) beats++;
    end
    for (int i = 0; i < 10 && end_beat == 0; i++) begin
      step(0, 8'd0, 1, 1, "stall_post", b, e);
      if (b) beats++;
      if (e) end_beat = beats;
    end
    n_tests++;
    if (end_beat != 5) begin
      n_fail++;
      $display("FAIL stall_len: frame end on beat %0d, want 5", end_beat);
    end

    // Reset mid-frame abandons it; the next 1-word frame still starts cleanly.
    do_reset("reset_pre_abort");
    step(1, 8'd5, 1, 1, "abort_cmd", b, e);
    step(0, 8'd0, 1, 1, "abort_b1", b, e);
    step(0, 8'd0, 1, 1, "abort_b2", b, e);
    do_reset("reset_mid_frame");
    step(1, 8'd0, 1, 1, "after_cmd", b, e);
    step(0, 8'd0, 1, 1, "after_beat", b, e);
    step(0, 8'd0, 1, 1, "after_idle", b, e);
    n_tests++;
    if (frame_cnt !== 2'd1) begin
      n_fail++;
      $display("FAIL after_cnt: frame_cnt=%0d, want 1", frame_cnt);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rand_reset");
      end else begin
        step(($urandom_range(0, 2) == 0), 8'($urandom_range(0, 6)),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0), "rand", b, e);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
